// File: rtl/vga_pkg.sv
// Shared VGA types: monitor states and
// the measured-timing record.
package vga_pkg;

  localparam int MON_CW = 11;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    VERIFY,
    LOCKED
  } mon_state_t;

  typedef struct packed {
    logic [MON_CW-1:0] h_total;
    logic [MON_CW-1:0] v_total;
    logic [MON_CW-1:0] h_active;
    logic [MON_CW-1:0] v_active;
  } timing_meas_t;

endpackage

// File: rtl/vga_if.sv
// VGA raster stream: counters, syncs,
// blanking and pixel colour.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in (
    input hcount, vcount, hsync,
    input vsync, hblnk, vblnk, rgb
  );

  modport out (
    output hcount, vcount, hsync,
    output vsync, hblnk, vblnk, rgb
  );
endinterface

// File: rtl/vga_sync_edge.sv
// Registers one sync/blank bit and flags
// its rising and falling edges.
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_d;

  // input register plus one-cycle history
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= d;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/vga_timing_monitor.sv
// Measures incoming VGA timing, locks on a
// stable mode and regenerates x/y/de.
module vga_timing_monitor
  import vga_pkg::*;
#(
  parameter int CW          = MON_CW,
  parameter int LOCK_FRAMES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  vga_if.in                    in,
  output logic                 locked,
  output logic [CW-1:0]        h_total,
  output logic [CW-1:0]        v_total,
  output logic [CW-1:0]        h_active,
  output logic [CW-1:0]        v_active,
  output logic [CW-1:0]        x,
  output logic [CW-1:0]        y,
  output logic                 de,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [3:0] LOCK_LAST =
    4'(LOCK_FRAMES - 1);

  logic [3:0] sig, lvl, rise, fall;
  logic hs_rise, vs_rise;
  logic hb, vb, hb_fall, vb_fall;

  mon_state_t state, nstate;
  timing_meas_t meas, cur;

  logic [CW-1:0] hc, ha, vc, va;
  logic [CW-1:0] h_first, a_first;
  logic [CW-1:0] line_len;
  logic line_first, frame_bad;
  logic [3:0] match_cnt;
  logic y_arm;

  logic tmo, line_diff, bad_now;
  logic frame_ok, line_mis;
  logic load_ref, inc_match, clr_match;
  logic mark_bad, err_set;

  assign sig = {in.vblnk, in.hblnk,
                in.vsync, in.hsync};

  for (genvar i = 0; i < 4; i++)
  begin : g_edge
    vga_sync_edge u_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (sig[i]),
      .q    (lvl[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign hs_rise = rise[0];
  assign vs_rise = rise[1];
  assign hb      = lvl[2];
  assign vb      = lvl[3];
  assign hb_fall = fall[2];
  assign vb_fall = fall[3];

  assign line_len = hc + 1'b1;
  assign tmo = (state != SEARCH) &&
               (hc == CMAX) && !hs_rise;
  assign line_diff = hs_rise && !line_first &&
    (line_len != h_first || ha != a_first);
  assign bad_now = frame_bad | line_diff;
  assign line_mis = hs_rise &&
    (line_len != meas.h_total ||
     ha != meas.h_active);
  assign frame_ok = !bad_now && (cur == meas);

  // frame being closed; a line ending on the
  // same clock as vsync still belongs to it
  always_comb begin
    cur = '0;
    cur.h_total  = (line_first && hs_rise) ?
                   line_len : h_first;
    cur.h_active = (line_first && hs_rise) ?
                   ha : a_first;
    cur.v_total  = vc + CW'(hs_rise);
    cur.v_active = va + CW'(hs_rise & ~vb);
  end

  // per-line clock and active-clock counters
  always_ff @(posedge clk) begin
    if (rst || tmo || hs_rise) begin
      hc <= '0;
      ha <= '0;
    end else begin
      if (hc != CMAX) hc <= hc + 1'b1;
      if (!hb) ha <= ha + 1'b1;
    end
  end

  // per-frame line and active-line counters
  always_ff @(posedge clk) begin
    if (rst || tmo || vs_rise) begin
      vc <= '0;
      va <= '0;
    end else if (hs_rise) begin
      vc <= vc + 1'b1;
      if (!vb) va <= va + 1'b1;
    end
  end

  // first line of frame and consistency flag
  always_ff @(posedge clk) begin
    if (rst || tmo) begin
      line_first <= 1'b1;
      frame_bad  <= 1'b0;
      h_first    <= '0;
      a_first    <= '0;
    end else if (vs_rise) begin
      line_first <= 1'b1;
      frame_bad  <= 1'b0;
    end else begin
      if (hs_rise && line_first) begin
        h_first    <= line_len;
        a_first    <= ha;
        line_first <= 1'b0;
      end
      if (line_diff || mark_bad)
        frame_bad <= 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= SEARCH;
    else     state <= nstate;
  end

  // next-state and datapath controls
  always_comb begin
    nstate    = state;
    load_ref  = 1'b0;
    inc_match = 1'b0;
    clr_match = 1'b0;
    mark_bad  = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      SEARCH: begin
        if (vs_rise) nstate = MEASURE;
      end
      MEASURE: begin
        if (tmo) begin
          nstate  = SEARCH;
          err_set = 1'b1;
        end else if (vs_rise && !bad_now) begin
          load_ref  = 1'b1;
          clr_match = 1'b1;
          nstate    = VERIFY;
        end
      end
      VERIFY: begin
        if (tmo) begin
          nstate  = SEARCH;
          err_set = 1'b1;
        end else if (vs_rise) begin
          if (!frame_ok) begin
            load_ref  = 1'b1;
            clr_match = 1'b1;
          end else if (match_cnt == LOCK_LAST) begin
            nstate = LOCKED;
          end else begin
            inc_match = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (tmo) begin
          nstate  = SEARCH;
          err_set = 1'b1;
        end else if (line_mis ||
                     (vs_rise && !frame_ok)) begin
          nstate   = MEASURE;
          err_set  = 1'b1;
          mark_bad = !vs_rise;
        end
      end
      default: nstate = SEARCH;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    locked = (state == LOCKED);
  end

  // reference timing and match counter
  always_ff @(posedge clk) begin
    if (rst) begin
      meas      <= '0;
      match_cnt <= '0;
    end else begin
      if (load_ref) meas <= cur;
      if (clr_match)
        match_cnt <= '0;
      else if (inc_match)
        match_cnt <= match_cnt + 1'b1;
    end
  end

  // error pulse and saturating error count
  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= err_set;
      if (err_set && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
    end
  end

  // regenerated coordinates and data enable
  always_ff @(posedge clk) begin
    if (rst) begin
      x     <= '0;
      y     <= '0;
      de    <= 1'b0;
      y_arm <= 1'b0;
    end else begin
      de <= ~hb & ~vb;
      if (hb_fall) x <= '0;
      else if (!hb) x <= x + 1'b1;
      if (vb_fall) begin
        y     <= '0;
        y_arm <= hb_fall;
      end else if (hb_fall && !vb) begin
        if (y_arm) y <= y + 1'b1;
        else       y_arm <= 1'b1;
      end
    end
  end

  assign h_total  = meas.h_total;
  assign v_total  = meas.v_total;
  assign h_active = meas.h_active;
  assign v_active = meas.v_active;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Scoreboard bench: small-raster generator,
// lock/error scenarios and x/y/de checks.
module tb_vga_timing_monitor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_if vif ();

  logic        locked, err, de;
  logic [10:0] h_total, v_total;
  logic [10:0] h_active, v_active;
  logic [10:0] x, y;
  logic [7:0]  err_cnt;

  vga_timing_monitor dut (
    .clk      (clk),
    .rst      (rst),
    .in       (vif),
    .locked   (locked),
    .h_total  (h_total),
    .v_total  (v_total),
    .h_active (h_active),
    .v_active (v_active),
    .x        (x),
    .y        (y),
    .de       (de),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s got=%0d exp=%0d",
                 tag, got, exp);
    end
  endtask

  // generator timing (mode A now, mode B pending)
  int ht = 48, hact = 32, hs0 = 36, hs1 = 40;
  int vt = 20, vact = 14, vs0 = 16, vs1 = 18;
  int gh = 0, gv = 0, line_ht = 48;
  bit stretch_req = 0, mode_req = 0;
  bit freeze = 0;
  int freeze_cnt = 0;

  int vs_seen = 0;
  int err_pulses = 0;
  int de_cnt = 0;
  bit frm_ok = 0;

  typedef struct {
    bit de;
    int x;
    int y;
  } exp_t;
  exp_t sbq[$];

  // raster generator and scoreboard
  initial begin
    bit hsn, vsn, hbn, vbn;
    exp_t e;
    vif.hsync = 0; vif.vsync = 0;
    vif.hblnk = 0; vif.vblnk = 0;
    vif.hcount = '0; vif.vcount = '0;
    vif.rgb = '0;
    forever begin
      @(negedge clk);
      hsn = !freeze && gh >= hs0 && gh < hs1;
      vsn = !freeze && gv >= vs0 && gv < vs1;
      hbn = freeze || gh >= hact;
      vbn = freeze || gv >= vact;
      frm_ok = frm_ok && locked;
      if (de && locked) de_cnt++;
      if (vsn && !vif.vsync) begin
        vs_seen++;
        if (frm_ok)
          chk("de_per_frame", de_cnt, hact * vact);
        frm_ok = locked;
        de_cnt = 0;
      end
      vif.hsync = hsn; vif.vsync = vsn;
      vif.hblnk = hbn; vif.vblnk = vbn;
      vif.hcount = 11'(gh);
      vif.vcount = 11'(gv);
      e.de = !hbn && !vbn; e.x = gh; e.y = gv;
      sbq.push_back(e);
      if (sbq.size() > 2) begin
        e = sbq.pop_front();
        if (locked) begin
          chk("de", de, e.de);
          if (e.de) begin
            chk("x", x, e.x);
            chk("y", y, e.y);
          end
        end
      end
      if (freeze) freeze_cnt++;
      if (gh + 1 >= line_ht) begin
        gh = 0;
        if (gv + 1 >= vt) begin
          gv = 0;
          if (freeze && freeze_cnt >= 2100)
            freeze = 0;
          if (mode_req) begin
            ht = 40; hact = 24; hs0 = 28; hs1 = 32;
            vt = 16; vact = 10; vs0 = 12; vs1 = 14;
            mode_req = 0;
          end
        end else begin
          gv++;
        end
        line_ht = ht;
        if (stretch_req && gv == 5) begin
          line_ht = ht + 1;
          stretch_req = 0;
        end
      end else begin
        gh++;
      end
    end
  end

  // err pulse width and pulse count
  initial begin
    int ew = 0;
    forever begin
      @(negedge clk);
      if (err) begin
        ew++;
      end else if (ew > 0) begin
        chk("err_width", ew, 1);
        err_pulses++;
        ew = 0;
      end
    end
  end

  task automatic wait_lock(input string tag);
    int n = 0;
    while (!locked && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, locked, 1);
  endtask

  task automatic wait_err(input string tag);
    int n = 0;
    while (!err && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, err, 1);
  endtask

  task automatic chk_meas(input string tag,
                          input int ht_e,
                          input int vt_e,
                          input int ha_e,
                          input int va_e);
    chk({tag, "_h_total"}, h_total, ht_e);
    chk({tag, "_v_total"}, v_total, vt_e);
    chk({tag, "_h_active"}, h_active, ha_e);
    chk({tag, "_v_active"}, v_active, va_e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_de"}, de, 0);
    chk_meas(tag, 0, 0, 0, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  // scenario sequence
  initial begin
    int vsb, p0, n;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    vs_seen = 0;

    wait_lock("lock_a");
    chk("lock_a_vs", vs_seen, 4);
    chk_meas("mode_a", 48, 20, 32, 14);
    chk("lock_a_err_cnt", err_cnt, 0);
    repeat (3 * 960) @(negedge clk);

    p0 = err_pulses;
    stretch_req = 1;
    wait_err("stretch_err");
    chk("stretch_locked", locked, 0);
    chk("stretch_err_cnt", err_cnt, 1);
    vsb = vs_seen;
    wait_lock("relock_stretch");
    chk("relock_stretch_vs", vs_seen - vsb, 4);
    chk("stretch_pulses", err_pulses - p0, 1);
    chk_meas("after_stretch", 48, 20, 32, 14);
    repeat (2 * 960) @(negedge clk);

    p0 = err_pulses;
    freeze = 1;
    n = 0;
    while (freeze && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("freeze_released", freeze, 0);
    chk("tmo_pulses", err_pulses - p0, 1);
    chk("tmo_locked", locked, 0);
    chk("tmo_err_cnt", err_cnt, 2);
    chk_meas("after_tmo", 48, 20, 32, 14);
    wait_lock("relock_tmo");
    repeat (960) @(negedge clk);

    p0 = err_pulses;
    mode_req = 1;
    wait_err("mode_err");
    chk("mode_err_cnt", err_cnt, 3);
    wait_lock("lock_b");
    chk("mode_pulses", err_pulses - p0, 1);
    chk_meas("mode_b", 40, 16, 24, 10);
    repeat (2 * 640) @(negedge clk);

    n = 0;
    while (gv != 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_mid_frame", gv, 5);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("mid_reset");
    rst = 1'b0;
    vsb = vs_seen;
    wait_lock("relock_reset");
    chk("relock_reset_vs", vs_seen - vsb, 4);
    chk_meas("after_reset", 40, 16, 24, 10);
    chk("after_reset_err_cnt", err_cnt, 0);
    repeat (2 * 640) @(negedge clk);

    $display("test done: total=%0d bad=%0d",
             n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Receiver-side counterpart of the VGA timing generator.
- Consumes hsync/vsync/hblnk/vblnk from a vga_if stream and measures line length, frame height and active area.
- Locks once the measured timing has been stable for a number of frames, then regenerates pixel coordinates (x, y) and a data-enable signal.
- Sits at the input of downstream draw/overlay stages, and in testbenches as a protocol checker on generator output.

Parameters:
- CW, 11, width of all counters and measured values.
- LOCK_FRAMES, 2, consecutive matching frames needed to assert locked (range 1..15).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- in   vga_if.in  -  hsync, vsync, hblnk, vblnk used (all active-high); hcount, vcount and rgb ignored
- locked  out  1  timing stable, x/y/de valid
- h_total  out  CW  clocks per line (hsync rise to hsync rise)
- v_total  out  CW  lines per frame (hsync rises between vsync rises)
- h_active  out  CW  hblnk=0 clocks per line
- v_active  out  CW  lines with vblnk=0 sampled at hsync rise
- x  out  CW  pixel column, 0 at first active clock of line
- y  out  CW  pixel row, 0 at first active line
- de  out  1  ~hblnk & ~vblnk, aligned with x/y
- err  out  1  one-cycle pulse on loss of lock or timeout
- err_cnt  out  ERR_CNT_W  saturating count of err pulses

Behaviour:
- Reset: all outputs are 0, the state machine is SEARCH and all internal counters are 0.
- Input stage: the four sync/blank inputs are registered once. Edges are detected on the registered copy against its previous value.
- Line counter hc:
  - Increments every clock.
  - On an hsync rising edge, hc+1 is captured as the line length, then hc clears to 0.
- Active counter ha:
  - Increments while hblnk=0.
  - Captured and cleared on the hsync rising edge.
- Line counter vc:
  - Increments on each hsync rising edge.
  - Captured and cleared on a vsync rising edge.
- Active-line counter va:
  - Increments on an hsync rising edge when vblnk=0.
  - Captured and cleared on a vsync rising edge.
- Simultaneous hsync and vsync rising edges: the line is counted first, then the vertical values are captured. That line belongs to the frame just ending.
- Frame record: per-line values must be identical for every line of a frame to count as consistent. Any line differing from the first line of the frame marks the frame bad.
- State machine:
  - SEARCH: wait for a vsync rising edge, then go to MEASURE.
  - MEASURE: one full frame. At the next vsync rising edge, store {h_total, v_total, h_active, v_active} as the reference. A bad frame returns to MEASURE. Otherwise go to VERIFY with match_cnt=0.
  - VERIFY: at each vsync rising edge, compare the frame with the reference. On a match, match_cnt++, and when it reaches LOCK_FRAMES go to LOCKED. On a mismatch or bad frame, reload the reference from this frame and stay in VERIFY with match_cnt=0.
  - LOCKED: locked=1. On any line or frame mismatch, pulse err, clear locked in the same cycle, and go to MEASURE.
- Timeout: if hc reaches 2^CW-1 with no hsync edge, pulse err, go to SEARCH, clear locked and clear all counters. This applies in every state except SEARCH.
- err_cnt: increments on each err pulse and saturates at 2^ERR_CNT_W-1. It is cleared only by rst.
- Measured outputs h_total, v_total, h_active and v_active:
  - Update only when the reference is stored or reloaded.
  - Hold their values through loss of lock.
- x: clears to 0 on an hblnk falling edge and increments while hblnk=0.
- y: clears to 0 on a vblnk falling edge and increments on each hblnk falling edge after the first line while vblnk=0.
- x/y/de latency: registered, latency 2 clocks from the input pins (input register plus output register). x/y are valid only while locked=1 and de=1.
- Reset mid-frame: returns to SEARCH. The first possible lock is after 1 + 1 + LOCK_FRAMES vsync rising edges.

Decomposition:
- vga_pkg gains:
  - typedef enum mon_state_t {SEARCH, MEASURE, VERIFY, LOCKED};
  - a struct timing_meas_t {h_total, v_total, h_active, v_active};
  - constant MON_CW=11.
- Sub-module vga_sync_edge: registers one sync/blank bit and outputs rise/fall pulses. It is instantiated four times.
- Counters, the state machine and the coordinate logic live in the top module.

Test Plan:
- Generator at 800x600 (HCOUNT_MAX=1055, VCOUNT_MAX=627), LOCK_FRAMES=2 -> locked rises at the 4th vsync rising edge; h_total=1056, v_total=628, h_active=800, v_active=600; err_cnt=0.
- After lock, de=1 first clock -> x=0, y=0; last active pixel -> x=799, y=599; de count per frame = 480000.
- After lock, stretch one line by 1 clock (1057) -> err pulses for exactly 1 cycle, locked=0, err_cnt=1; relock after 3 clean frames with the values unchanged.
- Hold hsync low for 2100 clocks -> err pulse, state SEARCH, locked=0, err_cnt increments.
- Switch the generator to 640x480 (800x525) while locked -> err once; new lock with h_total=800, v_total=525, h_active=640, v_active=480.
- Assert rst for 1 cycle mid-frame while locked -> all outputs 0 next cycle, including err_cnt; relock after 4 vsync rising edges.
